// File: rtl/mau_pkg.sv
// Shared types and helpers for the memory access unit: FSM states and device-select decoding.
package mau_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        ACCESS   = 2'd1,
        SYNCWAIT = 2'd2
    } mau_state_t;

    localparam logic [3:0] DEV_MEM = 4'h0;
    localparam logic [3:0] DEV_FP  = 4'h1;

    function automatic logic [3:0] dev_of(input logic [15:0] addr);
        return addr[15:12];
    endfunction

endpackage

// File: rtl/mau_wait_timer.sv
// Saturating Waitreq watchdog: counts stalled ACCESS cycles, expired is combinational in the stall cycle
// where the count has reached TIMEOUT-1. No backpressure; clear has priority over enable.
module mau_wait_timer #(
    parameter int TIMEOUT = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expired
);

    localparam int CNT_W = $clog2(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT - 1);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (en && (count_q != CNT_MAX)) begin
            count_d = count_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign expired = en && (count_q == CNT_MAX);

endmodule

// File: rtl/mem_access_unit.sv
// Memory pipeline stage: one load/store at a time onto an Avalon-style bus, load data returned as a pulse.
// MEM load 3 cycles, other loads 2, store frees ReqReady after 2; each Waitreq cycle adds one; ReqReady=0 while busy.
module mem_access_unit
    import mau_pkg::*;
#(
    parameter int TIMEOUT = 16,
    parameter int TAG_W   = 3
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic             ReqValid,
    input  logic             ReqWrite,
    input  logic [15:0]      ReqAddr,
    input  logic [15:0]      ReqData,
    input  logic [TAG_W-1:0] ReqDest,
    output logic             ReqReady,
    output logic             RespValid,
    output logic [15:0]      RespData,
    output logic [TAG_W-1:0] RespDest,
    output logic             BusErr,
    output logic [15:0]      DataAddr,
    output logic [15:0]      BusIn,
    output logic             ReadData,
    output logic             WriteData,
    input  logic [15:0]      BusOut,
    input  logic             Waitreq
);

    mau_state_t       state_q, state_d;
    logic [15:0]      addr_q, addr_d;
    logic [15:0]      wdata_q, wdata_d;
    logic             write_q, write_d;
    logic [TAG_W-1:0] dest_q, dest_d;
    logic             rd_q, rd_d;
    logic             wr_q, wr_d;
    logic             resp_vld_q, resp_vld_d;
    logic [15:0]      resp_data_q, resp_data_d;
    logic             err_q, err_d;

    logic accept;
    logic timer_en;
    logic expired;
    logic is_mem;

    assign accept   = (state_q == IDLE) && ReqValid;
    assign timer_en = (state_q == ACCESS) && Waitreq;
    assign is_mem   = (dev_of(addr_q) == DEV_MEM);

    mau_wait_timer #(
        .TIMEOUT(TIMEOUT)
    ) u_wait_timer (
        .clk    (Clock),
        .rst    (Reset),
        .clr    (accept),
        .en     (timer_en),
        .expired(expired)
    );

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (ReqValid) begin
                    state_d = ACCESS;
                end
            end
            ACCESS: begin
                if (!Waitreq) begin
                    // MEM returns read data one cycle after the strobe, so loads take a detour
                    state_d = (!write_q && is_mem) ? SYNCWAIT : IDLE;
                end else if (expired) begin
                    state_d = IDLE;
                end
            end
            SYNCWAIT: state_d = IDLE;
            default:  state_d = IDLE;
        endcase
    end

    always_comb begin
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        write_d     = write_q;
        dest_d      = dest_q;
        rd_d        = 1'b0;
        wr_d        = 1'b0;
        resp_vld_d  = 1'b0;
        resp_data_d = resp_data_q;
        err_d       = err_q;
        case (state_q)
            IDLE: begin
                if (ReqValid) begin
                    addr_d  = ReqAddr;
                    wdata_d = ReqData;
                    write_d = ReqWrite;
                    dest_d  = ReqDest;
                    err_d   = 1'b0;
                    rd_d    = !ReqWrite;
                    wr_d    = ReqWrite;
                end
            end
            ACCESS: begin
                if (!Waitreq) begin
                    if (!write_q && !is_mem) begin
                        resp_vld_d  = 1'b1;
                        resp_data_d = BusOut;
                    end
                end else if (expired) begin
                    // aborted loads still complete with zero data so writeback is never left waiting
                    err_d = 1'b1;
                    if (!write_q) begin
                        resp_vld_d  = 1'b1;
                        resp_data_d = '0;
                    end
                end else begin
                    rd_d = !write_q;
                    wr_d = write_q;
                end
            end
            SYNCWAIT: begin
                resp_vld_d  = 1'b1;
                resp_data_d = BusOut;
            end
            default: ;
        endcase
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            addr_q      <= '0;
            wdata_q     <= '0;
            write_q     <= 1'b0;
            dest_q      <= '0;
            rd_q        <= 1'b0;
            wr_q        <= 1'b0;
            resp_vld_q  <= 1'b0;
            resp_data_q <= '0;
            err_q       <= 1'b0;
        end else begin
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            write_q     <= write_d;
            dest_q      <= dest_d;
            rd_q        <= rd_d;
            wr_q        <= wr_d;
            resp_vld_q  <= resp_vld_d;
            resp_data_q <= resp_data_d;
            err_q       <= err_d;
        end
    end

    assign ReqReady  = (state_q == IDLE);
    assign RespValid = resp_vld_q;
    assign RespData  = resp_data_q;
    assign RespDest  = dest_q;
    assign BusErr    = err_q;
    assign DataAddr  = addr_q;
    assign BusIn     = wdata_q;
    assign ReadData  = rd_q;
    assign WriteData = wr_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Scoreboard bench for mem_access_unit: directed then random requests, a behavioural bus device and a response monitor.
module tb_mem_access_unit;
    import mau_pkg::*;

    localparam int TIMEOUT = 16;
    localparam int TAG_W   = 3;
    localparam int NRAND   = 150;

    logic             Clock = 1'b0;
    logic             Reset;
    logic             ReqValid;
    logic             ReqWrite;
    logic [15:0]      ReqAddr;
    logic [15:0]      ReqData;
    logic [TAG_W-1:0] ReqDest;
    logic             ReqReady;
    logic             RespValid;
    logic [15:0]      RespData;
    logic [TAG_W-1:0] RespDest;
    logic             BusErr;
    logic [15:0]      DataAddr;
    logic [15:0]      BusIn;
    logic             ReadData;
    logic             WriteData;
    logic [15:0]      BusOut;
    logic             Waitreq;

    mem_access_unit #(.TIMEOUT(TIMEOUT), .TAG_W(TAG_W)) dut (
        .Clock(Clock), .Reset(Reset),
        .ReqValid(ReqValid), .ReqWrite(ReqWrite), .ReqAddr(ReqAddr), .ReqData(ReqData),
        .ReqDest(ReqDest), .ReqReady(ReqReady),
        .RespValid(RespValid), .RespData(RespData), .RespDest(RespDest), .BusErr(BusErr),
        .DataAddr(DataAddr), .BusIn(BusIn), .ReadData(ReadData), .WriteData(WriteData),
        .BusOut(BusOut), .Waitreq(Waitreq)
    );

    always #5 Clock = ~Clock;

    // number of rising edges so far; an output seen at a negedge is sampled by edge cyc+1
    int cyc = 0;
    always @(posedge Clock) cyc++;

    typedef struct {
        logic             write;
        logic [15:0]      addr;
        logic [15:0]      data;
        logic [TAG_W-1:0] dest;
        int               wait_n;
        logic [15:0]      rdata;
        bit               hold;
        int               gap;
    } txn_t;

    typedef struct {
        logic [15:0]      data;
        logic [TAG_W-1:0] dest;
        int               resp_edge;
    } exp_t;

    txn_t list[$];
    txn_t bus_q[$];
    exp_t sb_q[$];

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (edge %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference timing, counted in rising edges from the accepting edge
    function automatic bit aborts(input txn_t t);
        return t.wait_n >= TIMEOUT;
    endfunction

    function automatic int resp_lat(input txn_t t);
        if (aborts(t)) return TIMEOUT + 1;
        return t.wait_n + ((dev_of(t.addr) == DEV_MEM) ? 3 : 2);
    endfunction

    function automatic int ready_lat(input txn_t t);
        if (!t.write) return resp_lat(t);
        return aborts(t) ? TIMEOUT + 1 : t.wait_n + 2;
    endfunction

    function automatic int strobe_cycles(input txn_t t);
        return aborts(t) ? TIMEOUT : t.wait_n + 1;
    endfunction

    // Response monitor
    exp_t mon_e;
    always @(negedge Clock) begin
        if (!Reset && RespValid) begin
            if (sb_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_resp: RespValid with data 0x%0h, required no response (edge %0d)", RespData, cyc);
            end else begin
                mon_e = sb_q.pop_front();
                check("resp_data", RespData, mon_e.data);
                check("resp_dest", RespDest, mon_e.dest);
                check("resp_cycle", cyc + 1, mon_e.resp_edge);
            end
        end
    end

    // Bus device: stalls wait_n cycles, then returns data (one cycle late for MEM)
    txn_t bus_cur;
    bit   bus_active = 1'b0;
    int   bus_k = 0;
    always @(negedge Clock) begin
        if (Reset) begin
            bus_active = 1'b0;
            Waitreq    = 1'b0;
            BusOut     = '0;
        end else if (ReadData || WriteData) begin
            if (!bus_active) begin
                bus_active = 1'b1;
                bus_k      = 0;
                if (bus_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_strobe: rd=%0b wr=%0b addr 0x%0h, required idle bus", ReadData, WriteData, DataAddr);
                    bus_cur.write  = WriteData;
                    bus_cur.addr   = DataAddr;
                    bus_cur.data   = BusIn;
                    bus_cur.wait_n = 0;
                    bus_cur.rdata  = '0;
                end else begin
                    bus_cur = bus_q.pop_front();
                end
            end
            check("strobe_rd", ReadData, !bus_cur.write);
            check("strobe_wr", WriteData, bus_cur.write);
            check("bus_addr", DataAddr, bus_cur.addr);
            if (bus_cur.write) check("bus_wdata", BusIn, bus_cur.data);
            Waitreq = (bus_k < bus_cur.wait_n);
            BusOut  = (!bus_cur.write && dev_of(bus_cur.addr) != DEV_MEM && bus_k == bus_cur.wait_n)
                      ? bus_cur.rdata : ~bus_cur.rdata;
            bus_k++;
        end else begin
            Waitreq = 1'($urandom);
            BusOut  = 16'($urandom);
            if (bus_active) begin
                bus_active = 1'b0;
                check("strobe_cycles", bus_k, strobe_cycles(bus_cur));
                if (!bus_cur.write && !aborts(bus_cur) && dev_of(bus_cur.addr) == DEV_MEM) begin
                    check("syncwait_addr", DataAddr, bus_cur.addr);
                    BusOut = bus_cur.rdata;
                end
            end
        end
    end

    task automatic drive_req(input txn_t t);
        ReqValid = 1'b1;
        ReqWrite = t.write;
        ReqAddr  = t.addr;
        ReqData  = t.data;
        ReqDest  = t.dest;
    endtask

    task automatic add(input logic w, input logic [15:0] a, input logic [15:0] d, input int dst,
                       input int wn, input logic [15:0] rd, input bit hold);
        txn_t t;
        t.write  = w;
        t.addr   = a;
        t.data   = d;
        t.dest   = TAG_W'(dst);
        t.wait_n = wn;
        t.rdata  = rd;
        t.hold   = hold;
        t.gap    = 0;
        list.push_back(t);
    endtask

    // Waits for ReqReady and checks when it returned relative to the previous accept
    task automatic wait_ready(input bit have_prev, input txn_t prev, input int prev_e);
        int waited = 0;
        while (!ReqReady && waited < 200) begin
            @(negedge Clock);
            waited++;
        end
        if (!ReqReady) begin
            n_checks++;
            n_fail++;
            $display("FAIL ready_timeout: ReqReady still 0 after %0d cycles, required 1", waited);
        end else if (have_prev) begin
            check("ready_cycle", cyc + 1, prev_e + ready_lat(prev));
            check("bus_err", BusErr, aborts(prev));
        end
    endtask

    txn_t  cur, prev, tr;
    exp_t  ex;
    bit    have_prev;
    int    prev_e, acc_e, r;
    logic [3:0] dsel;

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: simulation did not finish, required completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        Reset = 1'b1; ReqValid = 1'b0; ReqWrite = 1'b0;
        ReqAddr = '0; ReqData = '0; ReqDest = '0;
        repeat (3) @(negedge Clock);
        check("rst_ready", ReqReady, 1'b1);
        check("rst_resp_vld", RespValid, 1'b0);
        check("rst_rd", ReadData, 1'b0);
        check("rst_wr", WriteData, 1'b0);
        check("rst_err", BusErr, 1'b0);
        check("rst_addr", DataAddr, 16'h0);
        check("rst_busin", BusIn, 16'h0);
        check("rst_resp_data", RespData, 16'h0);
        check("rst_resp_dest", RespDest, '0);
        Reset = 1'b0;
        @(negedge Clock);

        add(1'b0, 16'h0005, 16'h0000, 1, 0,  16'h1234, 1'b0);
        add(1'b1, 16'h0010, 16'hBEEF, 0, 0,  16'h0000, 1'b1);
        add(1'b0, 16'h1002, 16'h0000, 2, 4,  16'h3C00, 1'b0);
        add(1'b0, 16'h1000, 16'h0000, 3, 40, 16'hABCD, 1'b0);
        add(1'b1, 16'h2000, 16'h0F0F, 0, 0,  16'h0000, 1'b1);
        add(1'b1, 16'h0044, 16'h1111, 0, 25, 16'h0000, 1'b0);
        add(1'b0, 16'h0045, 16'h0000, 4, 0,  16'h7777, 1'b1);
        add(1'b0, 16'h1003, 16'h0000, 5, 0,  16'h2468, 1'b1);
        add(1'b0, 16'h1004, 16'h0000, 6, 1,  16'h4321, 1'b1);
        add(1'b0, 16'h0046, 16'h0000, 6, 15, 16'h1357, 1'b1);
        add(1'b0, 16'h1046, 16'h0000, 7, 16, 16'h9BDF, 1'b0);
        add(1'b0, 16'hF046, 16'h0000, 2, 2,  16'h5A5A, 1'b1);

        for (int i = 0; i < NRAND; i++) begin
            case ($urandom_range(0, 3))
                0:       dsel = DEV_MEM;
                1:       dsel = DEV_FP;
                2:       dsel = 4'h2;
                default: dsel = 4'hF;
            endcase
            r = $urandom_range(0, 19);
            tr.write  = ($urandom_range(0, 2) == 0);
            tr.addr   = {dsel, 12'($urandom)};
            tr.data   = 16'($urandom);
            tr.dest   = TAG_W'($urandom);
            tr.wait_n = (r < 12) ? (r % 4) : ((r < 18) ? r : 30);
            tr.rdata  = 16'($urandom);
            tr.hold   = 1'($urandom);
            tr.gap    = $urandom_range(0, 2);
            list.push_back(tr);
        end

        have_prev = 1'b0;
        prev_e    = 0;
        foreach (list[i]) begin
            cur = list[i];
            if (cur.hold) drive_req(cur);
            else ReqValid = 1'b0;
            wait_ready(have_prev, prev, prev_e);
            if (!cur.hold) begin
                repeat (cur.gap) @(negedge Clock);
                drive_req(cur);
            end
            acc_e = cyc + 1;
            bus_q.push_back(cur);
            if (!cur.write) begin
                ex.data      = aborts(cur) ? 16'h0000 : cur.rdata;
                ex.dest      = cur.dest;
                ex.resp_edge = acc_e + resp_lat(cur);
                sb_q.push_back(ex);
            end
            @(negedge Clock);
            ReqValid = 1'b0;
            check("busy_after_accept", ReqReady, 1'b0);
            check("bus_err_cleared", BusErr, 1'b0);
            prev      = cur;
            prev_e    = acc_e;
            have_prev = 1'b1;
        end
        wait_ready(have_prev, prev, prev_e);
        repeat (5) @(negedge Clock);
        check("sb_drained", sb_q.size(), 0);
        check("bus_drained", bus_q.size(), 0);

        // Reset in the middle of a stalled FP load
        cur.write = 1'b0; cur.addr = 16'h1003; cur.data = 16'h0; cur.dest = 3'd5;
        cur.wait_n = 1000; cur.rdata = 16'h5555; cur.hold = 1'b0; cur.gap = 0;
        drive_req(cur);
        bus_q.push_back(cur);
        @(negedge Clock);
        ReqValid = 1'b0;
        repeat (4) @(negedge Clock);
        check("rd_before_reset", ReadData, 1'b1);
        Reset = 1'b1;
        @(negedge Clock);
        check("reset_rd", ReadData, 1'b0);
        check("reset_ready", ReqReady, 1'b1);
        check("reset_err", BusErr, 1'b0);
        check("reset_resp_vld", RespValid, 1'b0);
        @(negedge Clock);
        Reset = 1'b0;
        bus_q.delete();
        repeat (20) @(negedge Clock);
        check("post_reset_ready", ReqReady, 1'b1);
        check("post_reset_rd", ReadData, 1'b0);
        check("post_reset_sb", sb_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
